// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the end-of-run CPU state dumper.
package cpu_dump_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_PC  = 2'd0,
        KIND_REG = 2'd1,
        KIND_MEM = 2'd2
    } kind_e;

    localparam int IDX_W = 16;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_state_dumper_halt_detector.sv
// Flags a CPU halt once the PC has held the same value for HALT_STABLE consecutive edges.
module halt_detector
    import cpu_dump_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    output logic              halt_o
);

    localparam int SW = (HALT_STABLE > 0) ? $clog2(HALT_STABLE + 1) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_STABLE);

    logic [DATA_W-1:0] pc_q;
    logic              pc_q_valid;
    logic [SW-1:0]     stable_q;
    logic [SW-1:0]     stable_nxt;

    // Saturating so the pulse fires once per stall, not again on counter wrap.
    always_comb begin
        stable_nxt = '0;
        if (pc_q_valid && (pc_i == pc_q)) begin
            stable_nxt = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
        end
    end

    assign halt_o = (HALT_STABLE != 0) && (stable_nxt == STABLE_MAX) && (stable_q != STABLE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            pc_q_valid <= 1'b0;
            stable_q   <= '0;
        end else begin
            pc_q       <= pc_i;
            pc_q_valid <= 1'b1;
            stable_q   <= stable_nxt;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// End-of-run observer: triggers on cycle limit or PC halt, freezes the core and
// streams PC, register file and data memory over valid/ready with a running checksum.
module cpu_state_dumper
    import cpu_dump_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int MEM_WORDS   = 32,
    parameter int MAX_CYCLES  = 31,
    parameter int HALT_STABLE = 4,
    parameter int CNT_W       = 16,
    localparam int REG_AW     = addr_w(NUM_REGS),
    localparam int MEM_AW     = addr_w(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    output logic              freeze_o,
    output logic [REG_AW-1:0] reg_raddr_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic [MEM_AW-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [1:0]        dump_kind_o,
    output logic [IDX_W-1:0]  dump_index_o,
    output logic              dump_last_o,
    output logic              done_o,
    output logic              halted_by_pc_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
    localparam logic [31:0]      MAX_CYC  = 32'(MAX_CYCLES);

    state_e            state_q;
    state_e            state_nxt;
    kind_e             kind_q;
    kind_e             dump_kind_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] snap_q;
    logic [DATA_W-1:0] load_word;
    logic [CNT_W-1:0]  cycles_inc;
    logic              halt;
    logic              cyc_hit;
    logic              trigger;
    logic              last_item;

    halt_detector #(
        .DATA_W      (DATA_W),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt (
        .clk    (clk),
        .rst    (rst),
        .pc_i   (pc_i),
        .halt_o (halt)
    );

    assign cycles_inc = (&cycles_o) ? cycles_o : cycles_o + CNT_W'(1);
    assign cyc_hit    = (MAX_CYCLES != 0) && (32'(cycles_inc) == MAX_CYC);
    assign trigger    = (state_q == ST_RUN) && (halt || cyc_hit);
    assign last_item  = (kind_q == KIND_MEM) && (idx_q == MEM_LAST);
    assign dump_kind_o = dump_kind_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RUN:     if (trigger) state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_PRESENT;
            ST_PRESENT: if (dump_ready_i) state_nxt = dump_last_o ? ST_DONE : ST_LOAD;
            ST_DONE:    state_nxt = ST_DONE;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Read addresses follow the current item so the combinational read settles during LOAD.
    always_comb begin
        freeze_o     = (state_q != ST_RUN);
        dump_valid_o = (state_q == ST_PRESENT);
        done_o       = (state_q == ST_DONE);
        reg_raddr_o  = '0;
        mem_raddr_o  = '0;
        if (kind_q == KIND_REG) reg_raddr_o = idx_q[REG_AW-1:0];
        if (kind_q == KIND_MEM) mem_raddr_o = idx_q[MEM_AW-1:0];
    end

    always_comb begin
        case (kind_q)
            KIND_REG: load_word = reg_rdata_i;
            KIND_MEM: load_word = mem_rdata_i;
            default:  load_word = snap_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_o       <= '0;
            snap_q         <= '0;
            halted_by_pc_o <= 1'b0;
            kind_q         <= KIND_PC;
            idx_q          <= '0;
            dump_data_o    <= '0;
            dump_kind_q    <= KIND_PC;
            dump_index_o   <= '0;
            dump_last_o    <= 1'b0;
            checksum_o     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycles_o <= cycles_inc;
                    if (trigger) begin
                        snap_q         <= pc_i;
                        halted_by_pc_o <= halt;
                    end
                end
                ST_LOAD: begin
                    dump_data_o  <= load_word;
                    dump_kind_q  <= kind_q;
                    dump_index_o <= idx_q;
                    dump_last_o  <= last_item;
                end
                ST_PRESENT: begin
                    if (dump_ready_i) begin
                        checksum_o <= checksum_o + dump_data_o;
                        if (kind_q == KIND_PC) begin
                            kind_q <= KIND_REG;
                            idx_q  <= '0;
                        end else if ((kind_q == KIND_REG) && (idx_q == REG_LAST)) begin
                            kind_q <= KIND_MEM;
                            idx_q  <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Parametrised end-of-run observer for the simple-mips CPU.
- Counts cycles after reset release and triggers on a cycle limit or on a PC-stall halt.
- After triggering, freezes the core and streams PC, every register-file word and every data-memory word over a valid/ready port.
- Keeps a running checksum, so benches and FPGA builds get a self-checking dump instead of fixed-time hierarchical display.

Parameters:
DATA_W, 32, width of registers, memory words, PC and checksum
NUM_REGS, 32, register-file entries dumped
MEM_WORDS, 32, data-memory words dumped
MAX_CYCLES, 31, cycle-limit trigger; 0 disables
HALT_STABLE, 4, consecutive equal-PC cycles that count as halt; 0 disables
CNT_W, 16, cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pc_i  in  DATA_W  CPU program counter
freeze_o  out  1  stall request to CPU; high in every state except RUN
reg_raddr_o  out  clog2(NUM_REGS)  register-file read address
reg_rdata_i  in  DATA_W  register-file read data, combinational from address
mem_raddr_o  out  clog2(MEM_WORDS)  data-memory word read address
mem_rdata_i  in  DATA_W  data-memory read data, combinational from address
dump_valid_o  out  1  dump word valid
dump_ready_i  in  1  sink ready
dump_data_o  out  DATA_W  dump word
dump_kind_o  out  2  0=PC, 1=REG, 2=MEM
dump_index_o  out  16  index within kind
dump_last_o  out  1  final word of the dump
done_o  out  1  dump complete, sticky until reset
halted_by_pc_o  out  1  trigger cause was the PC halt
cycles_o  out  CNT_W  cycles counted up to the trigger, saturating
checksum_o  out  DATA_W  sum mod 2^DATA_W of all transferred words

Behaviour:
- Reset: clk and rst as listed; rst is asynchronous, active-low. While rst is low, every output is 0, including addresses, freeze_o and checksum_o. A reset asserted mid-dump aborts immediately, and counting restarts on release.
- States: RUN -> LOAD -> PRESENT -> (LOAD | DONE).
- RUN, cycle counting: cycles_o increments on each rising edge with rst high and saturates at all-ones.
- RUN, halt detection: pc_q registers pc_i, and pc_q_valid is set after the first edge. The stable counter increments when pc_q_valid and pc_i==pc_q, and clears otherwise.
- RUN, trigger: fires on the edge where cycles_o becomes MAX_CYCLES, or where the stable counter becomes HALT_STABLE. On that edge pc_i is captured as the PC snapshot and the state moves to LOAD.
- RUN, trigger cause: if both conditions fire on the same edge, halted_by_pc_o=1. It is set only on a halt trigger.
- LOAD, one cycle: drive the read address for the current item, then register the word into dump_data_o with its kind and index.
  - PC item: dump_data_o takes the snapshot.
  - REG item: reg_raddr_o=index.
  - MEM item: mem_raddr_o=index.
  - The next state is PRESENT, with dump_valid_o=1.
- PRESENT: dump_valid_o, dump_data_o, dump_kind_o, dump_index_o and dump_last_o stay stable until dump_valid_o && dump_ready_i.
  - On the transfer, checksum_o += dump_data_o and valid drops.
  - If it was the last word, go to DONE; otherwise advance the item and go to LOAD.
  - Throughput: one word per 2 cycles with ready held high.
- Order: PC (index 0), REG 0..NUM_REGS-1, MEM 0..MEM_WORDS-1. Total 1+NUM_REGS+MEM_WORDS words; dump_last_o is high only on MEM MEM_WORDS-1.
- Index wrap: from REG NUM_REGS-1 to MEM 0, the index resets to 0.
- DONE: done_o=1, freeze_o stays 1, dump_valid_o=0, and cycles_o/checksum_o are held. The block stays here until reset.
- Both triggers disabled: the block remains in RUN forever, with freeze_o=0 and no dump.

Decomposition:
- Package cpu_dump_pkg holds:
  - the state enum (RUN, LOAD, PRESENT, DONE);
  - the kind codes KIND_PC/KIND_REG/KIND_MEM;
  - the index width constant.
- Sub-module halt_detector: pc_q, pc_q_valid and the stable counter, with HALT_STABLE as its parameter and a single halt_o pulse as output.

Test Plan:
- Running PC: pc_i increments by 4 from 0 each cycle, reg[i]=i, mem[i]=2i, ready held high.
  - Trigger on edge 31: cycles_o=31, halted_by_pc_o=0, snapshot=120.
  - 65 words in order; last on MEM 31.
  - checksum_o = 120+496+992 = 1608; done_o=1; freeze_o=1 from the trigger edge on.
- Halt: pc_i held at 0x40 from reset release, HALT_STABLE=4.
  - Trigger on edge 5: cycles_o=5, halted_by_pc_o=1, first word kind=0, data=0x40.
- Backpressure: ready held low for 10 cycles while MEM index 7 is presented.
  - valid stays high; data=14, kind=2, index=7 all stable.
  - The checksum is unchanged until ready rises.
- Reset mid-dump: rst driven low while REG index 10 is presented.
  - All outputs go 0 asynchronously, including freeze_o, checksum_o and done_o.
  - After release, the block re-triggers at cycle 31.
- Simultaneous: MAX_CYCLES=5 with PC constant, HALT_STABLE=4.
  - Both conditions fire on edge 5; halted_by_pc_o=1 and exactly one dump sequence is produced.
- Disabled: MAX_CYCLES=0, HALT_STABLE=0, run 200 cycles.
  - freeze_o=0, dump_valid_o=0, cycles_o=200.
